// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: pipelined branch/jump resolver with a 2-bit saturating BHT.
//
// Each accepted op is resolved in one cycle. The result is held in a single
// output register under a valid/ready handshake. A consumed conditional op
// trains the BHT entry selected by its PC. Fetch reads that entry
// combinationally through query_pc/query_taken.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   flush             kill the held result and block accept this cycle
//   in_valid/in_ready input handshake (pc, imm, rs1_data, rs2_data, br_op, pred_taken)
//   out_valid/out_ready result handshake (taken, target, next_pc, mispredict)
//   query_pc/query_taken fetch-side BHT lookup, pre-update value
module branch_resolve_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 16,
  parameter int unsigned IDX_LSB     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      br_op,
  input  logic            pred_taken,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic [XLEN-1:0] next_pc,
  output logic            mispredict,
  input  logic [XLEN-1:0] query_pc,
  output logic            query_taken
);

  localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  localparam logic [4:0] OP_BEQ  = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b01001;
  localparam logic [4:0] OP_BLT  = 5'b01100;
  localparam logic [4:0] OP_BGE  = 5'b01101;
  localparam logic [4:0] OP_BLTU = 5'b01110;
  localparam logic [4:0] OP_BGEU = 5'b01111;
  localparam logic [4:0] OP_JMP  = 5'b11111;

  logic            out_valid_q, out_valid_d;
  logic            taken_q, taken_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] next_pc_q, next_pc_d;
  logic            mispredict_q, mispredict_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            cond_q, cond_d;
  logic [1:0]      bht_q [BHT_ENTRIES];
  logic [1:0]      bht_d [BHT_ENTRIES];

  logic            accept;
  logic            consume;
  logic            eval_taken;
  logic            eval_cond;
  logic [IDX_W-1:0] upd_idx;
  logic [IDX_W-1:0] qry_idx;

  // Handshake: flush blocks accept and discards the held result.
  assign in_ready = !flush && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready && !flush;

  assign upd_idx = pc_q[IDX_LSB +: IDX_W];
  assign qry_idx = query_pc[IDX_LSB +: IDX_W];

  // Read before this cycle's update; a same-index write shows up next cycle.
  assign query_taken = bht_q[qry_idx][1];

  // Condition evaluation over full-width operands.
  always_comb begin
    eval_taken = 1'b0;
    eval_cond  = 1'b0;
    unique case (br_op)
      OP_BEQ:  begin eval_cond = 1'b1; eval_taken = (rs1_data == rs2_data); end
      OP_BNE:  begin eval_cond = 1'b1; eval_taken = (rs1_data != rs2_data); end
      OP_BLT:  begin eval_cond = 1'b1; eval_taken = ($signed(rs1_data) <  $signed(rs2_data)); end
      OP_BGE:  begin eval_cond = 1'b1; eval_taken = ($signed(rs1_data) >= $signed(rs2_data)); end
      OP_BLTU: begin eval_cond = 1'b1; eval_taken = (rs1_data <  rs2_data); end
      OP_BGEU: begin eval_cond = 1'b1; eval_taken = (rs1_data >= rs2_data); end
      OP_JMP:  eval_taken = 1'b1;
      default: eval_taken = 1'b0;
    endcase
  end

  // Result register next-state.
  always_comb begin
    out_valid_d  = out_valid_q;
    taken_d      = taken_q;
    target_d     = target_q;
    next_pc_d    = next_pc_q;
    mispredict_d = mispredict_q;
    pc_d         = pc_q;
    cond_d       = cond_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d  = 1'b1;
      taken_d      = eval_taken;
      target_d     = pc + imm;
      next_pc_d    = eval_taken ? (pc + imm) : (pc + XLEN'(4));
      mispredict_d = eval_taken != pred_taken;
      pc_d         = pc;
      cond_d       = eval_cond;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
  end

  // BHT training on consume of a conditional op, saturating at 00 and 11.
  always_comb begin
    bht_d = bht_q;
    if (consume && cond_q) begin
      if (taken_q) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      target_q     <= '0;
      next_pc_q    <= '0;
      mispredict_q <= 1'b0;
      pc_q         <= '0;
      cond_q       <= 1'b0;
      for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= 2'b01;
    end else begin
      out_valid_q  <= out_valid_d;
      taken_q      <= taken_d;
      target_q     <= target_d;
      next_pc_q    <= next_pc_d;
      mispredict_q <= mispredict_d;
      pc_q         <= pc_d;
      cond_q       <= cond_d;
      bht_q        <= bht_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign taken      = taken_q;
  assign target     = target_q;
  assign next_pc    = next_pc_q;
  assign mispredict = mispredict_q;

endmodule
